// File: rtl/lsu_word_ram_bridge.sv
// lsu_word_ram_bridge
//   Load/store unit in front of a word-only data RAM (single write strobe,
//   asynchronous read). Turns CPU byte/halfword/word loads and stores into
//   RAM accesses. Sub-word stores are done as read-modify-write. Loads are
//   sign- or zero-extended. Misaligned or illegal requests get an error
//   response.
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   req_*         CPU request: valid/ready handshake, we, funct3, byte addr, store data
//   rsp_*         one-cycle completion pulse with error flag and load data
//   ram_*         RAM word address, write data, write strobe, read data
module lsu_word_ram_bridge #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic [31:0]       rsp_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_d,
    output logic              ram_we,
    input  logic [31:0]       ram_q
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MERGE,
        S_WRITE,
        S_ERR
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    state_t             state_q, state_d;
    logic [ADDR_W+1:0]  addr_q;
    logic [2:0]         f3_q;
    logic [31:0]        wdata_q;
    logic [31:0]        merge_q, merge_d;
    logic               accept;
    logic               req_legal, req_misaligned;
    logic [7:0]         load_byte;
    logic [15:0]        load_half;
    logic [31:0]        load_ext;

    // Address bits above the RAM window are ignored, so accesses alias.
    logic unused_addr_hi;
    assign unused_addr_hi = &{1'b0, req_addr[31:ADDR_W+2]};

    assign accept = req_valid && (state_q == S_IDLE);

    // Legality and alignment of the incoming request.
    always_comb begin
        req_legal      = 1'b0;
        req_misaligned = 1'b0;
        case (req_funct3)
            F3_B:  req_legal = 1'b1;
            F3_H:  begin req_legal = 1'b1;     req_misaligned = req_addr[0];    end
            F3_W:  begin req_legal = 1'b1;     req_misaligned = |req_addr[1:0]; end
            F3_BU: req_legal = !req_we;
            F3_HU: begin req_legal = !req_we;  req_misaligned = req_addr[0];    end
            default: req_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (!req_legal || req_misaligned) state_d = S_ERR;
                    else if (!req_we)                 state_d = S_LOAD;
                    else if (req_funct3 == F3_W)      state_d = S_WRITE;
                    else                              state_d = S_MERGE;
                end
            end
            S_MERGE: state_d = S_WRITE;
            S_LOAD,
            S_WRITE,
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Lane selection and extension of the RAM read data for loads.
    always_comb begin
        case (addr_q[1:0])
            2'd0:    load_byte = ram_q[7:0];
            2'd1:    load_byte = ram_q[15:8];
            2'd2:    load_byte = ram_q[23:16];
            default: load_byte = ram_q[31:24];
        endcase
        load_half = addr_q[1] ? ram_q[31:16] : ram_q[15:0];
        case (f3_q)
            F3_B:    load_ext = {{24{load_byte[7]}}, load_byte};
            F3_BU:   load_ext = {24'd0, load_byte};
            F3_H:    load_ext = {{16{load_half[15]}}, load_half};
            F3_HU:   load_ext = {16'd0, load_half};
            default: load_ext = ram_q;
        endcase
    end

    // Current word with the store lane replaced (SH when funct3[0] is set).
    always_comb begin
        merge_d = ram_q;
        if (f3_q[0]) begin
            if (addr_q[1]) merge_d[31:16] = wdata_q[15:0];
            else           merge_d[15:0]  = wdata_q[15:0];
        end else begin
            case (addr_q[1:0])
                2'd0:    merge_d[7:0]   = wdata_q[7:0];
                2'd1:    merge_d[15:8]  = wdata_q[7:0];
                2'd2:    merge_d[23:16] = wdata_q[7:0];
                default: merge_d[31:24] = wdata_q[7:0];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            f3_q    <= '0;
            wdata_q <= '0;
            merge_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q  <= req_addr[ADDR_W+1:0];
                f3_q    <= req_funct3;
                wdata_q <= req_wdata;
            end
            if (state_q == S_MERGE) begin
                merge_q <= merge_d;
            end
        end
    end

    // Response and write strobe are gated by rst so a reset arriving in the
    // final cycle of an operation abandons it without side effects.
    always_comb begin
        req_ready = (state_q == S_IDLE);
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        rsp_rdata = '0;
        ram_we    = 1'b0;
        ram_d     = '0;
        ram_addr  = addr_q[ADDR_W+1:2];
        case (state_q)
            S_LOAD: begin
                rsp_valid = !rst;
                rsp_rdata = rst ? '0 : load_ext;
            end
            S_WRITE: begin
                rsp_valid = !rst;
                ram_we    = !rst;
                ram_d     = (f3_q == F3_W) ? wdata_q : merge_q;
            end
            S_ERR: begin
                rsp_valid = !rst;
                rsp_err   = !rst;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lsu_word_ram_bridge.sv
module tb_lsu_word_ram_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic [9:0]  ram_addr;
    logic [31:0] ram_d;
    logic        ram_we;
    logic [31:0] ram_q;

    int total  = 0;
    int passed = 0;
    int cyc    = 0;

    typedef struct {
        logic        err;
        logic [31:0] rd;
        int          cyc;
    } rsp_t;

    typedef struct {
        logic [9:0]  a;
        logic [31:0] d;
        int          cyc;
    } wr_t;

    rsp_t rsp_q[$];
    wr_t  wr_q[$];

    logic [31:0] mem [0:1023];

    lsu_word_ram_bridge #(.ADDR_W(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_err    (rsp_err),
        .rsp_rdata  (rsp_rdata),
        .ram_addr   (ram_addr),
        .ram_d      (ram_d),
        .ram_we     (ram_we),
        .ram_q      (ram_q)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: 1024x32, write on edge, asynchronous read.
    initial for (int i = 0; i < 1024; i++) mem[i] = '0;
    always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_d;
    assign ram_q = mem[ram_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        else passed++;
    endtask

    // Monitor: pops the scoreboard whenever the DUT responds or writes.
    always @(negedge clk) begin
        rsp_t er;
        wr_t  ew;
        if (rsp_valid) begin
            if (rsp_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_rsp: got rsp_valid=1 err=%b rdata=%h expected none (cycle %0d)",
                         rsp_err, rsp_rdata, cyc);
            end else begin
                er = rsp_q.pop_front();
                chk("rsp_err",   {31'd0, rsp_err}, {31'd0, er.err});
                chk("rsp_rdata", rsp_rdata, er.rd);
                chk("rsp_cycle", cyc, er.cyc);
            end
        end
        if (ram_we) begin
            if (wr_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_write: got ram_we=1 addr=%h d=%h expected none (cycle %0d)",
                         ram_addr, ram_d, cyc);
            end else begin
                ew = wr_q.pop_front();
                chk("ram_addr",  {22'd0, ram_addr}, {22'd0, ew.a});
                chk("ram_d",     ram_d, ew.d);
                chk("wr_cycle",  cyc, ew.cyc);
            end
        end
    end

    // Issue one request; lat is cycles from the accepting edge to the response.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic e_err, input logic [31:0] e_rd,
                         input int lat, input logic e_wr, input logic [9:0] wa,
                         input logic [31:0] wdv);
        int budget = 0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        while (!req_ready && budget < 20) begin
            @(posedge clk); #1;
            budget++;
        end
        if (!req_ready) begin
            total++;
            $display("FAIL ready_timeout: got req_ready=0 expected 1 within 20 cycles");
            req_valid = 1'b0;
            return;
        end
        rsp_q.push_back('{e_err, e_rd, cyc + lat});
        if (e_wr) wr_q.push_back('{wa, wdv, cyc + lat});
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic ld(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] e_rd);
        issue(1'b0, f3, a, 32'd0, 1'b0, e_rd, 1, 1'b0, 10'd0, 32'd0);
    endtask

    task automatic st(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                      input logic [9:0] wa, input logic [31:0] wdv);
        issue(1'b1, f3, a, wd, 1'b0, 32'd0, (f3 == 3'b010) ? 1 : 2, 1'b1, wa, wdv);
    endtask

    task automatic bad(input logic we, input logic [2:0] f3, input logic [31:0] a);
        issue(we, f3, a, 32'hFFFF_FFFF, 1'b1, 32'd0, 1, 1'b0, 10'd0, 32'd0);
    endtask

    // SB that is abandoned by reset; stage 0 resets in MERGE, 1 in WRITE.
    task automatic sb_reset(input int stage);
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
        req_addr = 32'h10; req_wdata = 32'hAA;
        chk("ready_before_rst", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (stage == 1) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("ready_after_rst", {31'd0, req_ready}, 32'd1);
        chk("mem4_after_rst", mem[4], 32'h80FF7F01);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
        req_addr = '0; req_wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_req_ready", {31'd0, req_ready}, 32'd1);
        chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset_rsp_err",   {31'd0, rsp_err},   32'd0);
        chk("reset_rsp_rdata", rsp_rdata,          32'd0);
        chk("reset_ram_we",    {31'd0, ram_we},    32'd0);
        chk("reset_ram_addr",  {22'd0, ram_addr},  32'd0);
        chk("reset_ram_d",     ram_d,              32'd0);

        // Word store and load-back.
        st(3'b010, 32'h10, 32'hDEADBEEF, 10'd4, 32'hDEADBEEF);
        ld(3'b010, 32'h10, 32'hDEADBEEF);
        // Sub-word stores via read-modify-write.
        st(3'b000, 32'h11, 32'h55,   10'd4, 32'hDEAD55EF);
        st(3'b001, 32'h12, 32'h1234, 10'd4, 32'h123455EF);
        ld(3'b010, 32'h10, 32'h123455EF);

        // Extension cases.
        st(3'b010, 32'h10, 32'h80FF7F01, 10'd4, 32'h80FF7F01);
        ld(3'b000, 32'h12, 32'hFFFFFFFF);
        ld(3'b100, 32'h12, 32'h000000FF);
        ld(3'b000, 32'h11, 32'h0000007F);
        ld(3'b001, 32'h12, 32'hFFFF80FF);
        ld(3'b101, 32'h12, 32'h000080FF);
        ld(3'b000, 32'h13, 32'hFFFFFF80);
        ld(3'b001, 32'h10, 32'h00007F01);

        // Errors: no write, zero data, RAM unchanged.
        bad(1'b0, 3'b010, 32'h13);
        bad(1'b1, 3'b001, 32'h11);
        bad(1'b0, 3'b011, 32'h10);
        bad(1'b1, 3'b100, 32'h10);
        ld(3'b010, 32'h10, 32'h80FF7F01);

        // Reset in MERGE, then in WRITE.
        sb_reset(0);
        sb_reset(1);
        ld(3'b010, 32'h10, 32'h80FF7F01);

        // Aliasing modulo 4 KiB.
        st(3'b010, 32'h1004, 32'hCAFEF00D, 10'd1, 32'hCAFEF00D);
        ld(3'b010, 32'h4, 32'hCAFEF00D);

        // Request fields change while busy: only the accepted SB executes.
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
        req_addr = 32'h14; req_wdata = 32'h77;
        chk("hold_ready_idle", {31'd0, req_ready}, 32'd1);
        rsp_q.push_back('{1'b0, 32'd0, cyc + 2});
        wr_q.push_back('{10'd5, 32'h00000077, cyc + 2});
        @(posedge clk); #1;
        req_funct3 = 3'b010; req_addr = 32'h20; req_wdata = 32'h11111111;
        chk("hold_ready_merge", {31'd0, req_ready}, 32'd0);
        @(posedge clk); #1;
        req_addr = 32'h24;
        chk("hold_ready_write", {31'd0, req_ready}, 32'd0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("hold_ready_back", {31'd0, req_ready}, 32'd1);
        ld(3'b010, 32'h20, 32'h00000000);
        ld(3'b010, 32'h24, 32'h00000000);
        ld(3'b010, 32'h14, 32'h00000077);

        repeat (4) @(posedge clk);
        #1;
        chk("rsp_queue_drained", rsp_q.size(), 32'd0);
        chk("wr_queue_drained",  wr_q.size(),  32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
